// File: rtl/core_bus_ctrl_pkg.sv
// core_bus_ctrl_pkg: constants shared by the data-side bus controller and its
// posted write buffer.
//   - Default parameter values for the controller and write buffer.
//   - Remote FSM state encoding (IDLE, WR, RD).
//   - Write-buffer entry layout: one flat word {addr, data}. The data field
//     occupies the low DATA_WIDTH bits and the address sits above it.
package core_bus_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_MEM_SIZE   = 2048;
  localparam int unsigned DEF_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10
  } bus_state_e;

endpackage

// File: rtl/core_bus_ctrl_wbuf.sv
// core_wbuf: synchronous FIFO that buffers posted remote stores.
// Each entry is {addr, data}. The pointers wrap modulo DEPTH, so DEPTH must be
// a power of two that is at least 2. A push into a full buffer and a pop from
// an empty buffer are both ignored. The head entry and the entry behind it are
// both exposed. This lets the owner reload its output registers in the same
// cycle that it pops the head.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push_i, push_addr_i,  write a new {addr, data} entry at the tail
//   push_data_i
//   pop_i                 drop the head entry
//   head_addr_o/_data_o   oldest entry
//   next_addr_o/_data_o   entry behind the head (valid when count_o > 1)
//   full_o, empty_o       occupancy flags
//   count_o               number of valid entries (0..DEPTH)
module core_wbuf
  import core_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_WBUF_DEPTH,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [ADDR_WIDTH-1:0] head_addr_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [DATA_WIDTH-1:0] next_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   rd_next_s;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push_s;
  logic               do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign count_o   = count_q;
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rd_next_s = rd_ptr_q + PTR_W'(1);

  assign head_addr_o = mem_q[rd_ptr_q][ENTRY_W-1:DATA_WIDTH];
  assign head_data_o = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign next_addr_o = mem_q[rd_next_s][ENTRY_W-1:DATA_WIDTH];
  assign next_data_o = mem_q[rd_next_s][DATA_WIDTH-1:0];

  // Next-state computation for the pointers and the occupancy count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. The data path has no reset because the count and pointers
  // qualify every entry.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
    end
  end

endmodule

// File: rtl/core_bus_ctrl.sv
// core_bus_ctrl: data-side bus controller between the pipeline data port, the
// local SRAM data port and the shared remote bus.
//   - Address MSBs select the local window. Local accesses drive the SRAM
//     combinationally and never stall.
//   - Remote stores are posted into core_wbuf. The pipeline stalls only when
//     the buffer is full.
//   - Remote loads stall until the remote read completes. A load is issued
//     only after every buffered store has drained, so stores keep their order
//     relative to later loads.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   daddr, ddata_out               pipeline address and store data
//   dwrite_en, dread_en            pipeline store and load requests
//   ddata_in                       load data, valid the cycle after acceptance
//   stall                          pipeline must hold its request and retry
//   lmem_addr, lmem_we, lmem_wdata local SRAM data port (combinational)
//   lmem_q                         local SRAM read data (one-cycle latency)
//   remote_addr, remote_wren,      remote bus request (registered)
//   remote_rden, remote_write_val
//   remote_ready, remote_read_val  remote completion and read data
//   wbuf_level                     posted write buffer occupancy
module core_bus_ctrl
  import core_bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE        = DEF_MEM_SIZE,
  parameter int unsigned LOCAL_SEL_BITS  = 2,
  parameter int unsigned LOCAL_SEL_VALUE = 0,
  parameter int unsigned WBUF_DEPTH      = DEF_WBUF_DEPTH,
  localparam int unsigned LMEM_ADDR_WIDTH = $clog2(MEM_SIZE),
  localparam int unsigned WBUF_CNT_W      = $clog2(WBUF_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      daddr,
  input  logic [DATA_WIDTH-1:0]      ddata_out,
  input  logic                       dwrite_en,
  input  logic                       dread_en,
  output logic [DATA_WIDTH-1:0]      ddata_in,
  output logic                       stall,
  output logic [LMEM_ADDR_WIDTH-1:0] lmem_addr,
  output logic                       lmem_we,
  output logic [DATA_WIDTH-1:0]      lmem_wdata,
  input  logic [DATA_WIDTH-1:0]      lmem_q,
  output logic [ADDR_WIDTH-1:0]      remote_addr,
  output logic                       remote_wren,
  output logic                       remote_rden,
  output logic [DATA_WIDTH-1:0]      remote_write_val,
  input  logic                       remote_ready,
  input  logic [DATA_WIDTH-1:0]      remote_read_val,
  output logic [WBUF_CNT_W-1:0]      wbuf_level
);

  bus_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] rem_addr_q, rem_addr_d;
  logic [DATA_WIDTH-1:0] rem_wval_q, rem_wval_d;
  logic                  rem_wren_q, rem_wren_d;
  logic                  rem_rden_q, rem_rden_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_done_q, rd_done_d;
  logic                  last_local_q, last_local_d;

  logic                  local_s;
  logic                  rmt_load_s;
  logic                  rmt_store_s;
  logic                  stall_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wb_full_s;
  logic                  wb_empty_s;
  logic [WBUF_CNT_W-1:0] wb_count_s;
  logic [ADDR_WIDTH-1:0] head_addr_s, next_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s, next_data_s;

  assign local_s     = (daddr[ADDR_WIDTH-1 -: LOCAL_SEL_BITS] ==
                        LOCAL_SEL_BITS'(LOCAL_SEL_VALUE));
  assign rmt_load_s  = dread_en && !local_s;
  assign rmt_store_s = dwrite_en && !local_s;

  // A full buffer always stalls a store, even when a pop happens this cycle.
  // A remote load stalls until its data has been captured.
  assign stall_s = (rmt_store_s && wb_full_s) || (rmt_load_s && !rd_done_q);
  assign push_s  = rmt_store_s && !stall_s;

  assign lmem_addr  = daddr[LMEM_ADDR_WIDTH-1:0];
  assign lmem_wdata = ddata_out;
  assign lmem_we    = dwrite_en && local_s;

  assign stall            = stall_s;
  assign ddata_in         = last_local_q ? lmem_q : rdata_q;
  assign remote_addr      = rem_addr_q;
  assign remote_wren      = rem_wren_q;
  assign remote_rden      = rem_rden_q;
  assign remote_write_val = rem_wval_q;
  assign wbuf_level       = wb_count_s;

  core_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_addr_i (daddr),
    .push_data_i (ddata_out),
    .pop_i       (pop_s),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s),
    .next_addr_o (next_addr_s),
    .next_data_o (next_data_s),
    .full_o      (wb_full_s),
    .empty_o     (wb_empty_s),
    .count_o     (wb_count_s)
  );

  // Remote FSM next state, request registers, read capture and read-data source
  always_comb begin
    state_d      = state_q;
    rem_addr_d   = rem_addr_q;
    rem_wval_d   = rem_wval_q;
    rem_wren_d   = rem_wren_q;
    rem_rden_d   = rem_rden_q;
    rdata_d      = rdata_q;
    rd_done_d    = rd_done_q;
    pop_s        = 1'b0;
    last_local_d = last_local_q;

    if (!stall_s) begin
      last_local_d = local_s;
    end else begin
      last_local_d = last_local_q;
    end

    // Clear the completed load when the pipeline moves past it.
    if (rmt_load_s && !stall_s) begin
      rd_done_d = 1'b0;
    end else begin
      rd_done_d = rd_done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!wb_empty_s) begin
          rem_addr_d = head_addr_s;
          rem_wval_d = head_data_s;
          rem_wren_d = 1'b1;
          state_d    = ST_WR;
        end else if (push_s) begin
          // The buffer is empty, so the store being pushed becomes the head
          // at this edge. Present it to the bus right away.
          rem_addr_d = daddr;
          rem_wval_d = ddata_out;
          rem_wren_d = 1'b1;
          state_d    = ST_WR;
        end else if (rmt_load_s && !rd_done_q) begin
          rem_addr_d = daddr;
          rem_rden_d = 1'b1;
          state_d    = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (remote_ready) begin
          pop_s = 1'b1;
          if (wb_count_s > WBUF_CNT_W'(1)) begin
            rem_addr_d = next_addr_s;
            rem_wval_d = next_data_s;
          end else if (push_s) begin
            // The only entry behind the head is arriving at this same edge.
            rem_addr_d = daddr;
            rem_wval_d = ddata_out;
          end else begin
            rem_wren_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (remote_ready) begin
          rdata_d    = remote_read_val;
          rd_done_d  = 1'b1;
          rem_rden_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RD;
        end
      end
      default: begin
        rem_wren_d = 1'b0;
        rem_rden_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Controller state registers. Reset drops any in-flight remote request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rem_addr_q   <= {ADDR_WIDTH{1'b0}};
      rem_wval_q   <= {DATA_WIDTH{1'b0}};
      rem_wren_q   <= 1'b0;
      rem_rden_q   <= 1'b0;
      rdata_q      <= {DATA_WIDTH{1'b0}};
      rd_done_q    <= 1'b0;
      last_local_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rem_addr_q   <= rem_addr_d;
      rem_wval_q   <= rem_wval_d;
      rem_wren_q   <= rem_wren_d;
      rem_rden_q   <= rem_rden_d;
      rdata_q      <= rdata_d;
      rd_done_q    <= rd_done_d;
      last_local_q <= last_local_d;
    end
  end

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Directed testbench for core_bus_ctrl. It models the local SRAM (one-cycle
// read latency) and a remote memory that completes whenever remote_ready is
// high.
module tb_core_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] daddr;
  logic [15:0] ddata_out;
  logic        dwrite_en;
  logic        dread_en;
  logic [15:0] ddata_in;
  logic        stall;
  logic [10:0] lmem_addr;
  logic        lmem_we;
  logic [15:0] lmem_wdata;
  logic [15:0] lmem_q;
  logic [15:0] remote_addr;
  logic        remote_wren;
  logic        remote_rden;
  logic [15:0] remote_write_val;
  logic        remote_ready;
  logic [15:0] remote_read_val;
  logic [2:0]  wbuf_level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  core_bus_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .daddr            (daddr),
    .ddata_out        (ddata_out),
    .dwrite_en        (dwrite_en),
    .dread_en         (dread_en),
    .ddata_in         (ddata_in),
    .stall            (stall),
    .lmem_addr        (lmem_addr),
    .lmem_we          (lmem_we),
    .lmem_wdata       (lmem_wdata),
    .lmem_q           (lmem_q),
    .remote_addr      (remote_addr),
    .remote_wren      (remote_wren),
    .remote_rden      (remote_rden),
    .remote_write_val (remote_write_val),
    .remote_ready     (remote_ready),
    .remote_read_val  (remote_read_val),
    .wbuf_level       (wbuf_level)
  );

  // Local SRAM model: synchronous write, registered read (old data on collision)
  logic [15:0] lmem [2048];
  always @(posedge clk) begin
    if (lmem_we) lmem[lmem_addr] <= lmem_wdata;
    lmem_q <= lmem[lmem_addr];
  end

  // Remote memory model indexed by {addr[15:14], addr[5:0]}
  function automatic logic [7:0] ridx(input logic [15:0] a);
    return {a[15:14], a[5:0]};
  endfunction

  logic [15:0] rmem [256];
  always @(posedge clk) begin
    if (remote_wren && remote_ready) rmem[ridx(remote_addr)] <= remote_write_val;
  end
  assign remote_read_val = rmem[ridx(remote_addr)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (wbuf_level == 3'd0 && !remote_wren) break;
      tick();
    end
  endtask

  int          n;
  logic        bad;
  logic [15:0] a;

  initial begin
    reset = 1'b1; daddr = 16'h0000; ddata_out = 16'h0000;
    dwrite_en = 1'b0; dread_en = 1'b0; remote_ready = 1'b0;
    tick(); tick();
    chk("rst_wren",  {31'd0, remote_wren}, 32'd0);
    chk("rst_rden",  {31'd0, remote_rden}, 32'd0);
    chk("rst_addr",  {16'd0, remote_addr}, 32'd0);
    chk("rst_wval",  {16'd0, remote_write_val}, 32'd0);
    chk("rst_level", {29'd0, wbuf_level}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    tick();

    // Local store then load
    daddr = 16'h0010; ddata_out = 16'h1234; dwrite_en = 1'b1; #1;
    chk("loc_wr_stall", {31'd0, stall}, 32'd0);
    chk("loc_we",       {31'd0, lmem_we}, 32'd1);
    chk("loc_addr",     {21'd0, lmem_addr}, 32'h010);
    tick();
    dwrite_en = 1'b0; dread_en = 1'b1; #1;
    chk("loc_rd_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("loc_rdata", {16'd0, ddata_in}, 32'h1234);
    dread_en = 1'b0;

    // Posted stores with remote_ready low
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      daddr = 16'(16'h4000 + i); ddata_out = 16'(16'h1000 + i); dwrite_en = 1'b1; #1;
      if (stall) bad = 1'b1;
      tick();
    end
    chk("post_nostall", {31'd0, bad}, 32'd0);
    chk("post_level4",  {29'd0, wbuf_level}, 32'd4);
    chk("post_wren",    {31'd0, remote_wren}, 32'd1);
    chk("post_head",    {16'd0, remote_addr}, 32'h4000);
    daddr = 16'h4004; ddata_out = 16'h1004; #1;
    chk("full_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("full_stall2", {31'd0, stall}, 32'd1);
    remote_ready = 1'b1;
    tick();
    remote_ready = 1'b0; #1;
    chk("pop_unstall", {31'd0, stall}, 32'd0);
    chk("pop_level3",  {29'd0, wbuf_level}, 32'd3);
    chk("pop_next",    {16'd0, remote_addr}, 32'h4001);
    tick();
    dwrite_en = 1'b0; #1;
    chk("push5_level", {29'd0, wbuf_level}, 32'd4);
    remote_ready = 1'b1;
    drain(20);
    chk("drain_level", {29'd0, wbuf_level}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      a = 16'(16'h4000 + i);
      chk("drain_data", {16'd0, rmem[ridx(a)]}, 32'(32'h1000 + i));
    end

    // Ordering: a store followed immediately by a load of the same address
    remote_ready = 1'b0;
    daddr = 16'h8000; ddata_out = 16'hBEEF; dwrite_en = 1'b1; #1;
    tick();
    dwrite_en = 1'b0; dread_en = 1'b1; #1;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (remote_rden) bad = 1'b1;
      tick();
    end
    remote_ready = 1'b1;
    n = 0;
    while (stall && n < 20) begin
      if (remote_rden && rmem[ridx(16'h8000)] !== 16'hBEEF) bad = 1'b1;
      n++;
      tick();
    end
    chk("ord_rd_after_wr", {31'd0, bad}, 32'd0);
    chk("ord_unstall", {31'd0, stall}, 32'd0);
    tick();
    chk("ord_rdata", {16'd0, ddata_in}, 32'hBEEF);
    dread_en = 1'b0;

    // Preload remote 0xC002 = 0x5A5A through a remote store
    daddr = 16'hC002; ddata_out = 16'h5A5A; dwrite_en = 1'b1; #1;
    tick();
    dwrite_en = 1'b0; #1;
    drain(20);
    tick();

    // Remote load latency with remote_ready tied high
    daddr = 16'hC002; dread_en = 1'b1; #1;
    n = 0;
    while (stall && n < 10) begin
      n++;
      tick();
    end
    chk("lat_stall_cycles", 32'(n), 32'd2);
    tick();
    chk("lat_rdata", {16'd0, ddata_in}, 32'h5A5A);
    dread_en = 1'b0;

    // Parallel traffic: local loads while the buffer waits on the remote bus
    for (int i = 0; i < 3; i++) begin
      daddr = 16'(16'h0100 + i); ddata_out = 16'(16'hA000 + i); dwrite_en = 1'b1; #1;
      tick();
    end
    remote_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      daddr = 16'(16'h4010 + i); ddata_out = 16'(16'h2000 + i); #1;
      tick();
    end
    dwrite_en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      daddr = 16'(16'h0100 + (i % 3)); dread_en = 1'b1; #1;
      if (stall) bad = 1'b1;
      tick();
      chk("par_rdata", {16'd0, ddata_in}, 32'(32'hA000 + (i % 3)));
    end
    dread_en = 1'b0;
    chk("par_nostall", {31'd0, bad}, 32'd0);
    chk("par_level",   {29'd0, wbuf_level}, 32'd2);

    // Reset in the middle of a drain
    daddr = 16'h4012; ddata_out = 16'h2002; dwrite_en = 1'b1; #1;
    tick();
    dwrite_en = 1'b0; #1;
    chk("mid_level3", {29'd0, wbuf_level}, 32'd3);
    chk("mid_wren",   {31'd0, remote_wren}, 32'd1);
    reset = 1'b1; #1;
    chk("mrst_wren",  {31'd0, remote_wren}, 32'd0);
    chk("mrst_rden",  {31'd0, remote_rden}, 32'd0);
    chk("mrst_addr",  {16'd0, remote_addr}, 32'd0);
    chk("mrst_wval",  {16'd0, remote_write_val}, 32'd0);
    chk("mrst_level", {29'd0, wbuf_level}, 32'd0);
    tick();
    reset = 1'b0; remote_ready = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (remote_wren) bad = 1'b1;
    end
    chk("post_rst_nowren", {31'd0, bad}, 32'd0);
    chk("post_rst_level",  {29'd0, wbuf_level}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_bus_ctrl.md
# core_bus_ctrl

Data-side bus controller between a core's pipeline data port, its local data/instruction SRAM port and the shared remote bus. It replaces the fixed 16-bit direct-through decode with a parametrised address window and a posted write buffer. Remote stores retire without stalling the pipeline unless the buffer is full. Remote loads are ordered behind all buffered stores, and local accesses never stall.

## Interface
Parameters:
- DATA_WIDTH, 16, width of data words on all ports
- ADDR_WIDTH, 16, width of pipeline and remote addresses
- MEM_SIZE, 2048, local memory depth in words; LMEM_ADDR_WIDTH = $clog2(MEM_SIZE) is derived
- LOCAL_SEL_BITS, 2, number of address MSBs decoded for the local window
- LOCAL_SEL_VALUE, 0, value of those MSBs that selects local memory
- WBUF_DEPTH, 4, posted write buffer entries; power of two, at least 2

Ports (reset: reset, asynchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- daddr  in  ADDR_WIDTH  pipeline data address
- ddata_out  in  DATA_WIDTH  pipeline store data
- dwrite_en  in  1  pipeline store request
- dread_en  in  1  pipeline load request
- ddata_in  out  DATA_WIDTH  load data, valid the cycle after the load is accepted
- stall  out  1  pipeline must hold its request and retry
- lmem_addr  out  LMEM_ADDR_WIDTH  local SRAM data-port address
- lmem_we  out  1  local SRAM write enable
- lmem_wdata  out  DATA_WIDTH  local SRAM write data
- lmem_q  in  DATA_WIDTH  local SRAM read data, one cycle latency
- remote_addr  out  ADDR_WIDTH  remote bus address (registered)
- remote_wren  out  1  remote write request (registered)
- remote_rden  out  1  remote read request (registered)
- remote_write_val  out  DATA_WIDTH  remote write data (registered)
- remote_ready  in  1  remote completes the presented request at this edge
- remote_read_val  in  DATA_WIDTH  remote read data, valid while remote_ready is high on a read
- wbuf_level  out  $clog2(WBUF_DEPTH)+1  occupancy of the write buffer

## Operation
- Local decode: local = daddr[ADDR_WIDTH-1 -: LOCAL_SEL_BITS] == LOCAL_SEL_VALUE.
- Local memory drive: lmem_addr = daddr[LMEM_ADDR_WIDTH-1:0], lmem_wdata = ddata_out, lmem_we = dwrite_en && local. All three are combinational.
- Local accesses never stall, including while remote activity is in progress.
- Remote store: pushed into the write buffer at the first edge where stall is low.
  - stall = dwrite_en && !local && count == WBUF_DEPTH.
  - No full bypass, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle are legal; count is unchanged.
- Remote load: stall = dread_en && !local && !rd_done. The pipeline holds daddr and dread_en stable while stalled.
- Remote FSM, states IDLE, WR, RD:
  - IDLE: if the buffer is not empty, load the head into the remote output registers and go to WR. Otherwise, if a remote load is pending and rd_done is 0, load daddr and go to RD. Otherwise stay.
  - WR: hold the outputs. On remote_ready, pop. If the buffer is still non-empty after the pop, load the next entry and stay in WR; otherwise go to IDLE.
  - RD: on remote_ready, capture remote_read_val into rdata_q, set rd_done and go to IDLE.
- Ordering: a remote load is issued only when the buffer is empty and the state is IDLE. Buffered stores therefore always complete before a later load.
- rd_done clears at the edge where the pipeline advances (stall low with a remote load present).
- ddata_in mux: last_local is registered at every edge where stall is low. ddata_in = last_local ? lmem_q : rdata_q.
- Reset mid-operation: the buffer is flushed and buffered stores are discarded. An in-flight remote request is dropped without completion.

## Timing
- Reset values: remote_wren, remote_rden, remote_addr, remote_write_val = 0; rdata_q = 0; rd_done = 0; last_local = 1; state IDLE; count and pointers 0; wbuf_level = 0.
- Local load: ddata_in is valid one cycle after acceptance.
- Remote load with the buffer empty and remote_ready tied high:
  - cycle 0: request, stall = 1
  - cycle 1: remote_rden = 1
  - edge into cycle 2: capture; stall = 0 in cycle 2
  - cycle 3: ddata_in valid
- Remote store: zero stall if not full. remote_wren rises the cycle after the push when the FSM is IDLE.
- Remote outputs change only at edges: in IDLE transitions, or at the edge where remote_ready is sampled high.

## Structure
- A shared constants package/header holds the FSM state encodings (IDLE, WR, RD) and the write-buffer entry layout {addr, data}.
- Sub-module core_wbuf: synchronous FIFO of WBUF_DEPTH x (ADDR_WIDTH+DATA_WIDTH) with push, pop, full, empty and count; pointers wrap modulo WBUF_DEPTH.
- core_bus_ctrl holds the decode, stall logic, FSM and read-data mux. The core top level instantiates it alongside dpsram and the pipeline.

## Test plan
- Local store then load: write 0x1234 to 0x0010, then read 0x0010. Required: stall never asserts, and ddata_in = 0x1234 the cycle after the read.
- Posted stores: 4 back-to-back stores to 0x4000..0x4003 with remote_ready low. Required: no stall, wbuf_level = 4. A 5th store stalls until remote_ready pulses once.
- Ordering: store 0xBEEF to 0x8000, then immediately load 0x8000 from a remote model memory. Required: remote_rden only after remote_wren completes, and ddata_in = 0xBEEF.
- Remote load latency: buffer empty, remote_ready high, remote_read_val = 0x5A5A. Required: stall for exactly 2 cycles, and ddata_in = 0x5A5A in cycle 3.
- Parallel traffic: local loads during buffer drain with remote_ready low for 5 cycles. Required: the local loads are zero-stall with correct data.
- Reset mid-drain: assert reset with wbuf_level = 3 while in WR. Required: all remote outputs = 0 immediately and wbuf_level = 0; after reset deasserts, no remote_wren occurs.
